magnetron_power_ctrl: RTL and testbench
=======================================

MAGNETRON_POWER_CTRL -- requirements
Module: magnetron_power_ctrl

Interface
REQ-001 Parameter PWR_LEVELS, default 10, number of duty slots per power period and the maximum power level.
REQ-002 Parameter SLOT_CYCLES, default 4, clock cycles per duty slot.
REQ-003 Derived width PW = clog2(PWR_LEVELS+1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 startn  in  1  start/resume button, active-low level.
REQ-007 stopn  in  1  pause button, active-low level.
REQ-008 clearn  in  1  cancel button, active-low level.
REQ-009 door_closed  in  1  high = door shut.
REQ-010 timer_done  in  1  high = cook timer expired.
REQ-011 power_sel  in  PW  requested power level, 0..PWR_LEVELS.
REQ-012 mag_on  out  1  magnetron drive.
REQ-013 state  out  2  FSM state code.
REQ-014 done_pulse  out  1  one-cycle pulse on entry to DONE.

Function
REQ-015 Start event SHALL be startn sampled low at an edge while it was sampled high at the previous edge; a held-low startn SHALL produce exactly one start event.
REQ-016 States SHALL be IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-017 IDLE->RUN on start event with door_closed=1, timer_done=0, power_sel!=0; power_sel SHALL be latched into pwr_q at that edge; otherwise remain in IDLE.
REQ-018 RUN transitions in priority order: clearn=0 -> IDLE; door_closed=0 or stopn=0 -> PAUSE; timer_done=1 -> DONE; else stay.
REQ-019 PAUSE: clearn=0 -> IDLE; timer_done=1 -> DONE; start event with door_closed=1 -> RUN, keeping pwr_q; else stay.
REQ-020 DONE: clearn=0 or door_closed=0 -> IDLE; else stay; start events are ignored.
REQ-021 done_pulse SHALL be 1 for exactly the first cycle in which state=DONE.
REQ-022 Duty counters cyc_cnt (0..SLOT_CYCLES-1) and slot_idx (0..PWR_LEVELS-1) SHALL be zeroed on every entry to RUN and hold at zero outside RUN.
REQ-023 In RUN, cyc_cnt SHALL increment every cycle and wrap to 0 after SLOT_CYCLES-1; slot_idx SHALL increment on each cyc_cnt wrap and wrap to 0 after PWR_LEVELS-1.
REQ-024 mag_on = (state==RUN) AND door_closed AND (slot_idx < pwr_q); the door_closed term SHALL be combinational so an open door drops mag_on in the same cycle.
REQ-025 Consequently mag_on SHALL first rise in the cycle after the start-event edge when pwr_q>0, and pwr_q=PWR_LEVELS SHALL give continuous mag_on.
REQ-026 Simultaneous clearn=0 and start event: clear wins (the state SHALL be IDLE, or remain IDLE).
REQ-027 A power_sel change while in RUN or PAUSE SHALL NOT affect pwr_q.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, pwr_q=0, cyc_cnt=0, slot_idx=0, and the start-edge history register=1 (released); mag_on=0 and done_pulse=0 SHALL follow.
REQ-029 Reset SHALL override all inputs, including mid-RUN; the first start event after reset SHALL require a new high-to-low startn transition.

Structure
REQ-030 State codes and the PW width function SHALL live in shared package mag_ctrl_pkg.
REQ-031 The duty counters and slot compare SHALL be a sub-module mag_duty_gen (inputs clk, rst, en, restart, level; output duty), instantiated once.

Verification (PWR_LEVELS=4, SLOT_CYCLES=2)
REQ-032 power_sel=2, door closed, start event -> RUN next cycle; mag_on pattern 1 for 4 cycles, then 0 for 4 cycles, repeating.
REQ-033 Door opens mid-RUN -> mag_on=0 in the same cycle, state=PAUSE at next edge; door closes, start event -> RUN with counters restarted and pwr_q unchanged.
REQ-034 timer_done=1 in RUN -> state=DONE, done_pulse high for 1 cycle, mag_on=0; clearn=0 -> IDLE.
REQ-035 Start event with door_closed=0, or with power_sel=0 -> stays IDLE, mag_on=0; startn held low for 20 cycles after a valid start -> only one start event.
REQ-036 rst=1 mid-RUN -> IDLE and mag_on=0 after the edge; startn held low through reset release -> no restart.
REQ-037 clearn=0 and start event in the same cycle from PAUSE -> IDLE.

Source files
------------

// File: rtl/mag_ctrl_pkg.sv
// Shared state encoding and width helper for the magnetron power controller.
package mag_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bits needed to hold a power level in 0..levels.
   function automatic int pw_width(input int levels);
      return $clog2(levels + 1);
   endfunction

endpackage

// File: rtl/mag_duty_gen.sv
// Slot-based duty generator: the output is high during the first `level` slots of each power period.
module mag_duty_gen
   import mag_ctrl_pkg::*;
#(
   parameter  int PWR_LEVELS  = 10,
   parameter  int SLOT_CYCLES = 4,
   localparam int PW          = pw_width(PWR_LEVELS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          restart,
   input  logic [PW-1:0] level,
   output logic          duty
);

   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int SW = (PWR_LEVELS > 1) ? $clog2(PWR_LEVELS) : 1;

   logic [CW-1:0] cyc_cnt;
   logic [SW-1:0] slot_idx;

   // The counters sit at zero whenever the next cycle is not a RUN cycle.
   always_ff @(posedge clk) begin
      if (rst || restart || !en) begin
         cyc_cnt  <= '0;
         slot_idx <= '0;
      end else if (cyc_cnt == CW'(SLOT_CYCLES - 1)) begin
         cyc_cnt <= '0;
         if (slot_idx == SW'(PWR_LEVELS - 1)) slot_idx <= '0;
         else                                 slot_idx <= slot_idx + SW'(1);
      end else begin
         cyc_cnt <= cyc_cnt + CW'(1);
      end
   end

   assign duty = PW'(slot_idx) < level;

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Microwave magnetron controller: start/pause/cancel FSM plus slot-based power duty cycling.
module magnetron_power_ctrl
   import mag_ctrl_pkg::*;
#(
   parameter  int PWR_LEVELS  = 10,
   parameter  int SLOT_CYCLES = 4,
   localparam int PW          = pw_width(PWR_LEVELS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          startn,
   input  logic          stopn,
   input  logic          clearn,
   input  logic          door_closed,
   input  logic          timer_done,
   input  logic [PW-1:0] power_sel,
   output logic          mag_on,
   output logic [1:0]    state,
   output logic          done_pulse
);

   state_t        state_q, state_d;
   logic [PW-1:0] pwr_q;
   logic          start_hist;
   logic          start_block;
   logic          done_q;
   logic          start_ev;
   logic          duty;

   // start_block keeps a button held through reset from counting as a fresh press.
   assign start_ev = !startn && start_hist && !start_block;

   always_ff @(posedge clk) begin
      if (rst) begin
         start_hist  <= 1'b1;
         start_block <= !startn;
      end else begin
         start_hist <= startn;
         if (startn) start_block <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (start_ev && clearn && door_closed && !timer_done && power_sel != '0)
               state_d = ST_RUN;
         ST_RUN:
            if (!clearn)                     state_d = ST_IDLE;
            else if (!door_closed || !stopn) state_d = ST_PAUSE;
            else if (timer_done)             state_d = ST_DONE;
         ST_PAUSE:
            if (!clearn)                        state_d = ST_IDLE;
            else if (timer_done)                state_d = ST_DONE;
            else if (start_ev && door_closed)   state_d = ST_RUN;
         ST_DONE:
            if (!clearn || !door_closed) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pwr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
         if (state_q == ST_IDLE && state_d == ST_RUN) pwr_q <= power_sel;
      end
   end

   mag_duty_gen #(
      .PWR_LEVELS  (PWR_LEVELS),
      .SLOT_CYCLES (SLOT_CYCLES)
   ) u_duty (
      .clk     (clk),
      .rst     (rst),
      .en      (state_d == ST_RUN),
      .restart ((state_d == ST_RUN) && (state_q != ST_RUN)),
      .level   (pwr_q),
      .duty    (duty)
   );

   // Door term stays combinational so an opening door kills drive immediately.
   assign mag_on     = (state_q == ST_RUN) && door_closed && duty;
   assign state      = state_q;
   assign done_pulse = done_q;

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Randomized plus directed bench for magnetron_power_ctrl against a behavioural model.
module tb_magnetron_power_ctrl;

   localparam int PWR  = 4;
   localparam int SLOT = 2;
   localparam int PW   = $clog2(PWR + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
   logic          door_closed = 1'b1, timer_done = 1'b0;
   logic [PW-1:0] power_sel = '0;
   logic          mag_on, done_pulse;
   logic [1:0]    state;

   int n_checks = 0;
   int n_errors = 0;

   // model: 0 idle, 1 run, 2 pause, 3 done
   int m_st = 0, m_prev_st = 0, m_pwr = 0, m_run_t = 0;
   bit m_prev_sn = 1'b1, m_valid = 1'b0;

   always #5 clk = ~clk;

   magnetron_power_ctrl #(.PWR_LEVELS(PWR), .SLOT_CYCLES(SLOT)) dut (
      .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .timer_done(timer_done), .power_sel(power_sel),
      .mag_on(mag_on), .state(state), .done_pulse(done_pulse)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance the model at the edge.
   task automatic cyc(input bit sn, input bit sp, input bit cl, input bit dr,
                      input bit tm, input int ps, input bit r, input string tag);
      bit start;
      int nxt;
      startn = sn; stopn = sp; clearn = cl; door_closed = dr;
      timer_done = tm; power_sel = PW'(ps); rst = r;
      @(negedge clk);
      if (m_valid) begin
         chk({tag, ".state"}, int'(state), m_st);
         chk({tag, ".mag_on"}, int'(mag_on),
             int'(m_st == 1 && dr && ((m_run_t / SLOT) % PWR) < m_pwr));
         chk({tag, ".done"}, int'(done_pulse), int'(m_st == 3 && m_prev_st != 3));
      end
      if (r) begin
         m_st = 0; m_prev_st = 0; m_pwr = 0; m_run_t = 0; m_valid = 1'b1;
      end else begin
         start = !sn && m_prev_sn;
         nxt = m_st;
         case (m_st)
            0: if (start && cl && dr && !tm && ps != 0) begin nxt = 1; m_pwr = ps; end
            1: if (!cl) nxt = 0; else if (!dr || !sp) nxt = 2; else if (tm) nxt = 3;
            2: if (!cl) nxt = 0; else if (tm) nxt = 3; else if (start && dr) nxt = 1;
            default: if (!cl || !dr) nxt = 0;
         endcase
         m_run_t = (nxt == 1 && m_st == 1) ? m_run_t + 1 : 0;
         m_prev_st = m_st;
         m_st = nxt;
      end
      m_prev_sn = sn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit sn;
      #1;
      // reset and idle
      repeat (2) cyc(1, 1, 1, 1, 0, 0, 1, "reset");
      repeat (2) cyc(1, 1, 1, 1, 0, 2, 0, "idle");
      // start at level 2, hold startn low, change power_sel mid-run
      cyc(0, 1, 1, 1, 0, 2, 0, "start");
      repeat (20) cyc(0, 1, 1, 1, 0, 2, 0, "hold");
      repeat (6) cyc(1, 1, 1, 1, 0, 4, 0, "psel_chg");
      // door opens mid-run, then closes and resumes
      repeat (3) cyc(1, 1, 1, 0, 0, 4, 0, "door_open");
      cyc(1, 1, 1, 1, 0, 4, 0, "door_shut");
      cyc(0, 1, 1, 1, 0, 4, 0, "resume");
      repeat (10) cyc(1, 1, 1, 1, 0, 4, 0, "resumed");
      // timer expiry, start ignored in DONE, then cancel
      repeat (3) cyc(1, 1, 1, 1, 1, 4, 0, "timer");
      cyc(0, 1, 1, 1, 0, 4, 0, "done_start");
      cyc(1, 1, 0, 1, 0, 4, 0, "clear");
      // bad starts
      cyc(0, 1, 1, 0, 0, 3, 0, "start_door");
      cyc(1, 1, 1, 1, 0, 0, 0, "gap");
      cyc(0, 1, 1, 1, 0, 0, 0, "start_p0");
      cyc(1, 1, 1, 1, 0, 4, 0, "gap");
      // full power: continuous drive
      cyc(0, 1, 1, 1, 0, 4, 0, "start_full");
      repeat (12) cyc(1, 1, 1, 1, 0, 1, 0, "full");
      // reset mid-run with startn held low through release
      repeat (2) cyc(0, 1, 1, 1, 0, 2, 1, "rst_run");
      repeat (4) cyc(0, 1, 1, 1, 0, 2, 0, "held_low");
      cyc(1, 1, 1, 1, 0, 2, 0, "release");
      // pause via stop, then clear and start together
      cyc(0, 1, 1, 1, 0, 2, 0, "start2");
      repeat (3) cyc(1, 1, 1, 1, 0, 2, 0, "run2");
      cyc(1, 0, 1, 1, 0, 2, 0, "stop");
      cyc(1, 1, 1, 1, 0, 2, 0, "paused");
      cyc(0, 1, 0, 1, 0, 2, 0, "clr_start");
      repeat (2) cyc(1, 1, 1, 1, 0, 2, 0, "after_clr");
      // randomized traffic
      sn = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) sn = !sn;
         cyc(sn,
             $urandom_range(19) != 0,
             $urandom_range(24) != 0,
             $urandom_range(9) != 0,
             $urandom_range(19) == 0,
             $urandom_range(PWR),
             $urandom_range(99) == 0,
             "rand");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
